servo_pwm_gen: RTL
==================

Name: servo_pwm_gen

Overview:
- Consumes the four 8-bit servo angle commands (0–180 degrees) produced by the key/switch input block.
- Drives four hobby-servo PWM outputs: fixed 20 ms frame, pulse width linear from MIN_US (0°) to MAX_US (180°).
- Samples the angles once per frame and converts them with a shared serial divider.
- Applies the new widths at the following frame boundary, so pulses never glitch mid-frame.

Parameters:
- CLK_DIV, 50, clk cycles per microsecond tick (50 MHz board clock).
- PERIOD_US, 20000, frame length in µs.
- MIN_US, 1000, pulse width for 0°.
- MAX_US, 2000, pulse width for 180°.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  output enable; low forces all pwm_out low and holds the timebase at zero.
- angle1  in  8  channel 0 angle, degrees.
- angle2  in  8  channel 1 angle, degrees.
- angle3  in  8  channel 2 angle, degrees.
- angle4  in  8  channel 3 angle, degrees.
- pwm_out  out  4  servo pulses; bit0 = angle1 … bit3 = angle4.
- frame_start  out  1  single-cycle pulse at each frame boundary.
- busy  out  1  high while width conversion is in progress.

Behaviour:
- Reset values: pre_cnt=0, us_cnt=0, pwm_out=0, frame_start=0, busy=0, FSM=IDLE. All active_width and next_width = MIN_US+(MAX_US-MIN_US)/2 (1500 µs, i.e. centre).
- Timebase:
  - pre_cnt counts 0..CLK_DIV-1; tick when pre_cnt==CLK_DIV-1.
  - us_cnt increments on tick and wraps PERIOD_US-1 → 0.
  - Boundary = cycle with pre_cnt==0 && us_cnt==0.
- At each boundary (registered, same edge):
  - frame_start=1 for exactly one clk.
  - active_width[i] <= next_width[i].
  - The four angles are latched into shadow regs, each clamped: values >180 become 180.
  - FSM leaves IDLE.
- pwm_out[i] is registered: 1 when en && us_cnt < active_width[i], else 0. Pulse is high for exactly active_width[i]*CLK_DIV clks from the cycle after the boundary.
- FSM:
  - States: IDLE → LOAD → DIV → STORE, then back to LOAD for ch<3, or to IDLE after ch 3.
  - LOAD: numerator = shadow[ch]*(MAX_US-MIN_US), 18 bits.
  - DIV: restoring unsigned divide by 180, one quotient bit per clk, 18 clks.
  - STORE: next_width[ch] = MIN_US + quotient (floor).
  - busy is high in every state except IDLE. Conversion takes about 80 clks, well inside one frame.
- Latency: angles present at boundary N affect pulses starting at boundary N+1. Angle changes between boundaries are ignored until the next sample.
- Boundary while busy: cannot occur with legal params (PERIOD_US*CLK_DIV > 100). If it does anyway, the restart wins: abort, re-latch, restart at ch 0, and leave next_width entries already stored untouched.
- en low:
  - pre_cnt and us_cnt are held at 0 and pwm_out is 0; no boundaries occur.
  - On en rising, the first boundary occurs the next clk.
- Reset mid-frame: all outputs go low asynchronously; widths return to centre.
- Arithmetic: widths are 11 bits unsigned, us_cnt is 15 bits. Quotient is never above MAX_US-MIN_US.

Decomposition:
- Shared package servo_pkg holds:
  - ANGLE_MAX=180, ANGLE_W=8, NUM_CH=4.
  - typedef angle_t (logic[7:0]).
  - typedef width_t (logic[10:0]).
  - FSM state enum.
- Sub-module serial_udiv:
  - Parameterised widths; start/done handshake; fixed divisor input.
  - Instantiated once and time-shared across channels.

Test Plan:
- Reset release, CLK_DIV=2, PERIOD_US=3000, angles all 0 → first frame: all pwm_out high 1500 µs (3000 clks). Second frame: 1000 µs (2000 clks).
- angle1=180, angle2=90, angle3=1, angle4=0 → from second frame, widths 2000/1500/1005/1000 µs. frame_start period is 6000 clks.
- angle1=200 → clamped; width 2000 µs, same as 180.
- Change angle2 from 90 to 45 mid-frame → current and next frame unchanged at 1500. Frame after boundary sampling: 1250 µs.
- Drop en mid-pulse → pwm_out=0 next clk and frame_start stops. Raise en → frame_start next clk, widths unchanged.
- Assert rst during pulse → pwm_out=0 immediately. After release, widths are 1500 µs.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and constants for the four-channel servo PWM generator.
// Angles are 8-bit degrees, widths are 11-bit microseconds.
package servo_pkg;

  localparam int ANGLE_MAX = 180;
  localparam int ANGLE_W   = 8;
  localparam int NUM_CH    = 4;
  localparam int WIDTH_W   = 11;
  localparam int NUM_W     = 18;

  typedef logic [ANGLE_W-1:0] angle_t;
  typedef logic [WIDTH_W-1:0] width_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DIV   = 2'd2,
    ST_STORE = 2'd3
  } fsm_state_e;

  function automatic angle_t clamp_angle(input angle_t a);
    return (a > angle_t'(ANGLE_MAX)) ? angle_t'(ANGLE_MAX) : a;
  endfunction

endpackage

// File: rtl/serial_udiv.sv
// Restoring unsigned divider, one quotient bit per clock.
// A start pulse (re)loads the operands and aborts any division in flight.
module serial_udiv #(
  parameter int NUM_W = 18,
  parameter int DEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic [NUM_W-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
  logic [NUM_W-1:0] quo_reg;
  logic [DEN_W-1:0] rem_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             done_reg;
  logic [DEN_W:0]   trial;

  assign trial = {rem_reg, quo_reg[NUM_W-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_reg  <= '0;
      rem_reg  <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        quo_reg <= dividend;
        rem_reg <= '0;
        cnt_reg <= CNT_W'(NUM_W);
      end else if (cnt_reg != '0) begin
        if (trial >= {1'b0, divisor}) begin
          rem_reg <= DEN_W'(trial - {1'b0, divisor});
          quo_reg <= {quo_reg[NUM_W-2:0], 1'b1};
        end else begin
          rem_reg <= trial[DEN_W-1:0];
          quo_reg <= {quo_reg[NUM_W-2:0], 1'b0};
        end
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) done_reg <= 1'b1;
      end
    end
  end

  assign quotient = quo_reg;
  assign done     = done_reg;

endmodule

// File: rtl/servo_pwm_gen.sv
// Four-channel hobby-servo PWM generator with a fixed frame and per-frame angle sampling.
// Widths are computed serially during a frame and take effect at the next frame boundary.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CLK_DIV   = 50,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ANGLE_W-1:0] angle1,
  input  logic [ANGLE_W-1:0] angle2,
  input  logic [ANGLE_W-1:0] angle3,
  input  logic [ANGLE_W-1:0] angle4,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic               frame_start,
  output logic               busy
);

  localparam int     PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int     US_W     = 15;
  localparam int     SPAN     = MAX_US - MIN_US;
  localparam width_t CENTER_W = width_t'(MIN_US + SPAN / 2);
  localparam int     CH_W     = $clog2(NUM_CH);

  logic [PRE_W-1:0]  pre_cnt_reg;
  logic [US_W-1:0]   us_cnt_reg;
  logic              tick;
  logic              boundary;
  angle_t            angle_in [NUM_CH];
  angle_t            shadow_reg [NUM_CH];
  width_t            active_width_reg [NUM_CH];
  width_t            next_width_reg [NUM_CH];
  logic [NUM_CH-1:0] pwm_next;
  fsm_state_e        state_reg;
  logic [CH_W-1:0]   ch_reg;
  logic              div_start;
  logic              div_done;
  logic [NUM_W-1:0]  div_dividend;
  logic [NUM_W-1:0]  div_quotient;

  assign angle_in[0] = angle1;
  assign angle_in[1] = angle2;
  assign angle_in[2] = angle3;
  assign angle_in[3] = angle4;

  assign tick     = (pre_cnt_reg == PRE_W'(CLK_DIV - 1));
  assign boundary = en && (pre_cnt_reg == '0) && (us_cnt_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_reg <= '0;
      us_cnt_reg  <= '0;
    end else if (!en) begin
      pre_cnt_reg <= '0;
      us_cnt_reg  <= '0;
    end else begin
      pre_cnt_reg <= tick ? '0 : pre_cnt_reg + 1'b1;
      if (tick)
        us_cnt_reg <= (us_cnt_reg == US_W'(PERIOD_US - 1)) ? '0 : us_cnt_reg + 1'b1;
    end
  end

  // On the boundary cycle compare against the incoming width so the new pulse is exact.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      width_t eff_width;
      assign eff_width    = boundary ? next_width_reg[gi] : active_width_reg[gi];
      assign pwm_next[gi] = en && (us_cnt_reg < US_W'(eff_width));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_reg[i]       <= '0;
        active_width_reg[i] <= CENTER_W;
        next_width_reg[i]   <= CENTER_W;
      end
      pwm_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      pwm_out     <= pwm_next;
      if (boundary) begin
        for (int i = 0; i < NUM_CH; i++) begin
          active_width_reg[i] <= next_width_reg[i];
          shadow_reg[i]       <= clamp_angle(angle_in[i]);
        end
      end else if (state_reg == ST_STORE) begin
        next_width_reg[ch_reg] <= width_t'(MIN_US + int'(div_quotient));
      end
    end
  end

  // A boundary always restarts the conversion sequence from channel 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      ch_reg    <= '0;
    end else if (boundary) begin
      state_reg <= ST_LOAD;
      ch_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE:  state_reg <= ST_IDLE;
        ST_LOAD:  state_reg <= ST_DIV;
        ST_DIV:   if (div_done) state_reg <= ST_STORE;
        ST_STORE: begin
          if (ch_reg == CH_W'(NUM_CH - 1)) begin
            state_reg <= ST_IDLE;
          end else begin
            ch_reg    <= ch_reg + 1'b1;
            state_reg <= ST_LOAD;
          end
        end
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  assign div_start    = (state_reg == ST_LOAD);
  assign div_dividend = NUM_W'(shadow_reg[ch_reg]) * NUM_W'(SPAN);
  assign busy         = (state_reg != ST_IDLE);

  serial_udiv #(
    .NUM_W (NUM_W),
    .DEN_W (ANGLE_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (ANGLE_W'(ANGLE_MAX)),
    .quotient (div_quotient),
    .done     (div_done)
  );

endmodule
